// File: rtl/aes_round_seq.sv
// rtl/aes_round_seq.sv - iterative AES round sequencer wrapped around a combinational aes_en_de round
module aes_round_seq #(
  parameter int NR = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_en_de,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] rnd_block,
  output logic [127:0] rnd_key,
  output logic         rnd_en_de,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  generate
    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
      $error("aes_round_seq: NR must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [3:0] LP_NR = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_fsm;
  state_t       w_fsm_nxt;
  logic [3:0]   r_cnt;
  logic [127:0] r_state;
  logic         r_mode;
  logic         w_accept;

  assign w_accept = (r_fsm == S_IDLE) && in_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm   <= S_IDLE;
      r_cnt   <= 4'd0;
      r_state <= 128'd0;
      r_mode  <= 1'b1;
    end else begin
      r_fsm <= w_fsm_nxt;
      case (r_fsm)
        S_IDLE: begin
          // Initial AddRoundKey is folded into the accept cycle.
          if (w_accept) begin
            r_state <= in_block ^ rk_data;
            r_mode  <= in_en_de;
            r_cnt   <= 4'd1;
          end
        end
        S_ROUND: begin
          r_state <= rnd_result;
          r_cnt   <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rnd_last  = 1'b0;
    rk_idx    = 4'd0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        rk_idx   = in_en_de ? 4'd0 : LP_NR;
        if (in_valid) w_fsm_nxt = S_ROUND;
      end
      S_ROUND: begin
        rk_idx   = r_mode ? r_cnt : (LP_NR - r_cnt);
        rnd_last = (r_cnt == LP_NR);
        if (r_cnt == LP_NR) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        // Hold the last-used key index so the key store input stays quiet while stalled.
        rk_idx    = r_mode ? LP_NR : 4'd0;
        out_valid = 1'b1;
        if (out_ready) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  assign rnd_block = r_state;
  assign rnd_key   = rk_data;
  assign rnd_en_de = r_mode;
  assign out_block = r_state;

endmodule

// File: tb/tb_aes_round_seq.sv
// tb/tb_aes_round_seq.sv - bench for aes_round_seq (NR=10 and NR=14) against a behavioural AES model
module tb_aes_round_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst  [2];
  logic         iv   [2];
  logic         ir   [2];
  logic         ied  [2];
  logic [127:0] ib   [2];
  logic [3:0]   rki  [2];
  logic [127:0] rkd  [2];
  logic [127:0] rbl  [2];
  logic [127:0] rky  [2];
  logic         red  [2];
  logic         rl   [2];
  logic [127:0] rr   [2];
  logic         ov   [2];
  logic         ordy [2];
  logic [127:0] ob   [2];

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk10  [0:14];
  logic [127:0] rk14  [0:14];

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_round_seq #(.NR(10)) u_dut10 (
    .clock(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_en_de(ied[0]),
    .in_block(ib[0]), .rk_idx(rki[0]), .rk_data(rkd[0]), .rnd_block(rbl[0]), .rnd_key(rky[0]),
    .rnd_en_de(red[0]), .rnd_last(rl[0]), .rnd_result(rr[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_block(ob[0])
  );

  aes_round_seq #(.NR(14)) u_dut14 (
    .clock(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_en_de(ied[1]),
    .in_block(ib[1]), .rk_idx(rki[1]), .rk_data(rkd[1]), .rnd_block(rbl[1]), .rnd_key(rky[1]),
    .rnd_en_de(red[1]), .rnd_last(rl[1]), .rnd_result(rr[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_block(ob[1])
  );

  // GF(2^8) arithmetic and AES primitives on a 128-bit block, byte 0 in the top bits.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] x, input int i);
    return x[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? isbox[gb(x, i)] : sbox[gb(x, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_r(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = gb(x, r+4*c);
        else     o[127-8*(r+4*c) -: 8] = gb(x, r+4*((c+r)%4));
    return o;
  endfunction

  function automatic logic [127:0] mix_c(input logic [127:0] x, input bit inv);
    logic [127:0] o;
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    cf[0] = inv ? 8'd14 : 8'd2;
    cf[1] = inv ? 8'd11 : 8'd3;
    cf[2] = inv ? 8'd13 : 8'd1;
    cf[3] = inv ? 8'd9  : 8'd1;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j-i+4)%4], gb(x, 4*c+j));
        o[127-8*(4*c+i) -: 8] = acc;
      end
    return o;
  endfunction

  // Stand-in for the combinational aes_en_de round.
  function automatic logic [127:0] aes_round(input logic [127:0] b, input logic [127:0] k,
                                             input logic enc, input logic last);
    logic [127:0] t;
    if (enc) begin
      t = shift_r(sub_b(b, 1'b0), 1'b0);
      if (!last) t = mix_c(t, 1'b0);
      return t ^ k;
    end
    t = sub_b(shift_r(b, 1'b1), 1'b1) ^ k;
    if (!last) t = mix_c(t, 1'b1);
    return t;
  endfunction

  function automatic logic [127:0] key_of(input int u, input int r);
    return (u == 0) ? rk10[r] : rk14[r];
  endfunction

  // Whole-cipher reference written as the textbook Cipher / InvCipher loops.
  function automatic logic [127:0] aes_ref(input logic [127:0] blk, input bit enc, input int u);
    logic [127:0] s;
    int nr;
    nr = (u == 0) ? 10 : 14;
    if (enc) begin
      s = blk ^ key_of(u, 0);
      for (int r = 1; r < nr; r++) s = mix_c(shift_r(sub_b(s, 1'b0), 1'b0), 1'b0) ^ key_of(u, r);
      s = shift_r(sub_b(s, 1'b0), 1'b0) ^ key_of(u, nr);
    end else begin
      s = blk ^ key_of(u, nr);
      for (int r = nr - 1; r > 0; r--) s = mix_c(sub_b(shift_r(s, 1'b1), 1'b1) ^ key_of(u, r), 1'b1);
      s = sub_b(shift_r(s, 1'b1), 1'b1) ^ key_of(u, 0);
    end
    return s;
  endfunction

  assign rkd[0] = (rki[0] <= 4'd10) ? rk10[rki[0]] : 128'd0;
  assign rkd[1] = (rki[1] <= 4'd14) ? rk14[rki[1]] : 128'd0;
  assign rr[0]  = aes_round(rbl[0], rky[0], red[0], rl[0]);
  assign rr[1]  = aes_round(rbl[1], rky[1], red[1], rl[1]);

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++) if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ 8'h63;
      b = inv;
      for (int n = 0; n < 4; n++) begin
        b = {b[6:0], b[7]};
        s = s ^ b;
      end
      sbox[i]  = s;
      isbox[s] = 8'(i);
    end
  endtask

  task automatic expand(input logic [255:0] key, input int nk, input int u);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      if (u == 0) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else        rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with the DUT idle; returns just after the release negedge.
  task automatic run_block(input int u, input logic [127:0] blk, input bit enc, input int stall,
                           input bit keep_valid, input logic [127:0] exp, output time t_acc);
    int nr;
    nr = (u == 0) ? 10 : 14;
    ied[u] = enc;
    ib[u]  = blk;
    iv[u]  = 1'b1;
    #1;
    chk("idle_in_ready", 128'(ir[u]), 128'd1);
    chk("idle_rk_idx", 128'(rki[u]), enc ? 128'd0 : 128'(nr));
    t_acc = $time;
    @(negedge clk);
    if (!keep_valid) iv[u] = 1'b0;
    for (int k = 1; k <= nr; k++) begin
      if (k == 1) chk("round1_block", rbl[u], blk ^ key_of(u, enc ? 0 : nr));
      chk("round_rk_idx", 128'(rki[u]), enc ? 128'(k) : 128'(nr - k));
      chk("round_key", rky[u], key_of(u, enc ? k : nr - k));
      chk("round_last", 128'(rl[u]), 128'(k == nr));
      chk("round_en_de", 128'(red[u]), 128'(enc));
      chk("round_busy", 128'({ir[u], ov[u]}), 128'd0);
      @(negedge clk);
    end
    chk("done_valid", 128'(ov[u]), 128'd1);
    chk("done_block", ob[u], exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 128'(ov[u]), 128'd1);
      chk("stall_block", ob[u], exp);
      chk("stall_in_ready", 128'(ir[u]), 128'd0);
    end
    ordy[u] = 1'b1;
    @(negedge clk);
    ordy[u] = 1'b0;
    chk("release_idle", 128'({ir[u], ov[u]}), 128'd2);
  endtask

  initial begin
    time t_now;
    time t_prev;
    logic [127:0] blk;
    bit enc;

    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; iv[u] = 1'b0; ied[u] = 1'b1; ib[u] = 128'd0; ordy[u] = 1'b0;
    end
    build_sbox();
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 0);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    chk("reset_in_ready", 128'(ir[0]), 128'd1);
    chk("reset_out_valid", 128'(ov[0]), 128'd0);
    chk("reset_state", rbl[0], 128'd0);
    chk("reset_mode", 128'(red[0]), 128'd1);
    chk("reset_last", 128'(rl[0]), 128'd0);
    chk("reset_rk_idx_enc", 128'(rki[0]), 128'd0);
    ied[0] = 1'b0;
    #1;
    chk("reset_rk_idx_dec", 128'(rki[0]), 128'd10);
    @(negedge clk);

    run_block(0, PT, 1'b1, 0, 1'b0, CT1, t_now);
    run_block(0, CT1, 1'b0, 0, 1'b0, PT, t_now);

    run_block(0, PT, 1'b1, 20, 1'b1, CT1, t_now);
    run_block(0, CT1, 1'b0, 0, 1'b0, PT, t_now);

    ied[0] = 1'b1; ib[0] = PT; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_rk_idx", 128'(rki[0]), 128'd5);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("post_reset_in_ready", 128'(ir[0]), 128'd1);
    chk("post_reset_out_valid", 128'(ov[0]), 128'd0);
    chk("post_reset_mode", 128'(red[0]), 128'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("aborted_never_valid", 128'(ov[0]), 128'd0);
    end
    run_block(0, CT1, 1'b0, 0, 1'b0, PT, t_now);

    run_block(1, PT, 1'b1, 0, 1'b0, CT3, t_now);
    run_block(1, CT3, 1'b0, 3, 1'b0, PT, t_now);

    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      enc = (i % 2 == 0);
      run_block(0, blk, enc, 0, 1'b0, aes_ref(blk, enc, 0), t_now);
      if (i > 0) chk("b2b_spacing", 128'(t_now - t_prev), 128'd120);
      t_prev = t_now;
    end
    for (int i = 0; i < 2; i++) begin
      blk = {$urandom(), $urandom(), $urandom(), $urandom()};
      enc = (i == 1);
      run_block(1, blk, enc, 0, 1'b0, aes_ref(blk, enc, 1), t_now);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
